buyruk_getir: RTL and testbench



---
 rtl/getir_paket.sv | 25 ++
 rtl/buyruk_fifo.sv | 86 ++++++++
 rtl/buyruk_getir.sv | 119 +++++++++++
 tb/tb_buyruk_getir.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/getir_paket.sv
// +----------------------------------------------------------------------------+
// | getir_paket                                                                |
// | Shared constants and FIFO entry type for the buyruk_getir fetch unit.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef BB_ADRES_BIT
`define BB_ADRES_BIT 8
`endif

package getir_paket;

  localparam logic [31:0] NOP_BUYRUK  = 32'h0000_0013;
  localparam int unsigned BUYRUK_BAYT = 4;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] buyruk;
    logic        hata;
  } getir_girdi_t;

endpackage

`default_nettype wire

// File: rtl/buyruk_fifo.sv
// +----------------------------------------------------------------------------+
// | buyruk_fifo                                                                |
// | Generic synchronous FIFO with flush; head entry is always presented.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module buyruk_fifo
  import getir_paket::*;
#(
  parameter int  FIFO_DEPTH = 2,
  parameter type T          = getir_girdi_t
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              push_i,
  input  T                                  push_data_i,
  input  logic                              pop_i,
  input  logic                              flush_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output T                                  head_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = FIFO_DEPTH[CW-1:0];

  T              mem_q [FIFO_DEPTH];
  T              mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  always_comb begin
    // A pop against an empty FIFO has nothing to remove.
    pop_eff  = pop_i && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_eff})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && !pop_eff && (count_q == FULL_COUNT)));

endmodule

`default_nettype wire

// File: rtl/buyruk_getir.sv
// +----------------------------------------------------------------------------+
// | buyruk_getir                                                               |
// | Instruction fetch: PC, SRAM read issue, instruction FIFO, redirect flush.  |
// | Optional macro BUYRUK_GETIR_SINIR_EN adds out-of-range fetch reporting.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module buyruk_getir
  import getir_paket::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ket_gecerli_i,
  input  logic [31:0]              ket_ps_i,
  input  logic                     coz_hazir_i,
  output logic                     buyruk_gecerli_o,
  output logic [31:0]              buyruk_o,
  output logic [31:0]              buyruk_ps_o,
`ifdef BUYRUK_GETIR_SINIR_EN
  output logic                     buyruk_hata_o,
`endif
  output logic [`BB_ADRES_BIT-1:0] bb_addra_o,
  output logic                     bb_ena_o,
  output logic [3:0]               bb_wea_o,
  output logic [31:0]              bb_dina_o,
  input  logic [31:0]              bb_douta_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic          inflight_hata_q, inflight_hata_d;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop, issue, push, pc_sinir_disi;
  getir_girdi_t  head, push_data;
  logic          unused_ok;

  assign pop              = buyruk_gecerli_o & coz_hazir_i;
  assign buyruk_gecerli_o = (count != '0);

`ifdef BUYRUK_GETIR_SINIR_EN
  assign pc_sinir_disi = (pc_q[31:`BB_ADRES_BIT+2] != '0);
  assign buyruk_hata_o = head.hata;
`else
  assign pc_sinir_disi = 1'b0;
`endif

  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    issue     = !rst_i && !ket_gecerli_i && (occupancy < DEPTH_C);
    // An out-of-range fetch still occupies a slot but never touches the SRAM.
    bb_ena_o  = issue && !pc_sinir_disi;

    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_pc_d   = inflight_pc_q;
    inflight_hata_d = inflight_hata_q;
    if (ket_gecerli_i) begin
      pc_d = {ket_ps_i[31:2], 2'b00};
    end else if (issue) begin
      pc_d            = pc_q + 32'(BUYRUK_BAYT);
      inflight_pc_d   = pc_q;
      inflight_hata_d = pc_sinir_disi;
    end

    // Data returning during a redirect belongs to the old path and is dropped.
    push             = inflight_q && !ket_gecerli_i;
    push_data.ps     = inflight_pc_q;
    push_data.buyruk = inflight_hata_q ? NOP_BUYRUK : bb_douta_i;
    push_data.hata   = inflight_hata_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q            <= {RESET_PC[31:2], 2'b00};
      inflight_q      <= 1'b0;
      inflight_pc_q   <= '0;
      inflight_hata_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_pc_q   <= inflight_pc_d;
      inflight_hata_q <= inflight_hata_d;
    end
  end

  buyruk_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (getir_girdi_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (ket_gecerli_i),
    .count_o     (count),
    .head_o      (head)
  );

  assign buyruk_o    = head.buyruk;
  assign buyruk_ps_o = head.ps;
  assign bb_addra_o  = pc_q[`BB_ADRES_BIT+1:2];
  assign bb_wea_o    = 4'b0000;
  assign bb_dina_o   = 32'h0;

  assign unused_ok = &{1'b0, ket_ps_i[1:0], pc_q[1:0], pc_q[31:`BB_ADRES_BIT+2], head.hata};

endmodule

`default_nettype wire

// File: tb/tb_buyruk_getir.sv
// +----------------------------------------------------------------------------+
// | tb_buyruk_getir                                                            |
// | Self-checking bench for buyruk_getir with a scoreboard of decode entries.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef BB_ADRES_BIT
`define BB_ADRES_BIT 8
`endif

module tb_buyruk_getir;

  localparam int DEPTH = 2;
  localparam int AW    = `BB_ADRES_BIT;

  typedef struct packed {
    logic [31:0] ps;
    logic [31:0] ins;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          ket_gecerli_i = 1'b0;
  logic [31:0]   ket_ps_i = 32'h0;
  logic          coz_hazir_i = 1'b1;
  logic          buyruk_gecerli_o;
  logic [31:0]   buyruk_o, buyruk_ps_o;
  logic [AW-1:0] bb_addra_o;
  logic          bb_ena_o;
  logic [3:0]    bb_wea_o;
  logic [31:0]   bb_dina_o;
  logic [31:0]   bb_douta_i = 32'h0;
`ifdef BUYRUK_GETIR_SINIR_EN
  logic          buyruk_hata_o;
`endif

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  buyruk_getir #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ket_gecerli_i    (ket_gecerli_i),
    .ket_ps_i         (ket_ps_i),
    .coz_hazir_i      (coz_hazir_i),
    .buyruk_gecerli_o (buyruk_gecerli_o),
    .buyruk_o         (buyruk_o),
    .buyruk_ps_o      (buyruk_ps_o),
`ifdef BUYRUK_GETIR_SINIR_EN
    .buyruk_hata_o    (buyruk_hata_o),
`endif
    .bb_addra_o       (bb_addra_o),
    .bb_ena_o         (bb_ena_o),
    .bb_wea_o         (bb_wea_o),
    .bb_dina_o        (bb_dina_o),
    .bb_douta_i       (bb_douta_i)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds 0x1000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (bb_ena_o) bb_douta_i <= 32'h1000 + 32'(bb_addra_o);
  end

  task automatic push_stream(input logic [31:0] start_ps, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = ((start_ps >> 2) + 32'(i)) & ((32'd1 << AW) - 1);
      exp_q.push_back({start_ps + 32'(4 * i), 32'h1000 + w});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1; ket_gecerli_i = 1'b0; ket_ps_i = 32'h0; coz_hazir_i = 1'b1;
    @(negedge clk); #1;
    n_chk += 5;
    if (buyruk_gecerli_o !== 1'b0) begin n_fail++; $display("FAIL rst_gecerli: got %b required 0", buyruk_gecerli_o); end
    if (buyruk_o !== 32'h0) begin n_fail++; $display("FAIL rst_buyruk: got %h required 0", buyruk_o); end
    if (buyruk_ps_o !== 32'h0) begin n_fail++; $display("FAIL rst_ps: got %h required 0", buyruk_ps_o); end
    if (bb_ena_o !== 1'b0) begin n_fail++; $display("FAIL rst_ena: got %b required 0", bb_ena_o); end
    if (bb_wea_o !== 4'b0 || bb_dina_o !== 32'h0) begin n_fail++; $display("FAIL rst_tie: got wea %h dina %h required 0", bb_wea_o, bb_dina_o); end
  endtask

  task automatic test_startup();
    exp_t e;
    exp_q.delete();
    push_stream(32'h0, 40);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      rst_i = 1'b0; coz_hazir_i = 1'b1; ket_gecerli_i = 1'b0;
      #1;
      if (k == 1) begin
        n_chk++;
        if (bb_ena_o !== 1'b1 || bb_addra_o !== '0) begin n_fail++; $display("FAIL start_ena: got ena %b addr %h required 1 0", bb_ena_o, bb_addra_o); end
      end
      n_chk++;
      if (buyruk_gecerli_o !== (k >= 3)) begin n_fail++; $display("FAIL start_gecerli c%0d: got %b required %b", k, buyruk_gecerli_o, k >= 3); end
      if (buyruk_gecerli_o && coz_hazir_i) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL start_sb: got ps %h required no entry", buyruk_ps_o); end
        else begin
          e = exp_q.pop_front();
          if (buyruk_ps_o !== e.ps || buyruk_o !== e.ins) begin n_fail++; $display("FAIL start_sb: got ps %h ins %h required ps %h ins %h", buyruk_ps_o, buyruk_o, e.ps, e.ins); end
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int n_ena = 0;
    exp_q.delete();
    push_stream(32'h0, 40);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rst_i = 1'b0; ket_gecerli_i = 1'b0;
      coz_hazir_i = !(k >= 3 && k <= 7);
      #1;
      if (k <= 7 && bb_ena_o) n_ena++;
      if (k >= 3 && k <= 7) begin
        n_chk += 2;
        if (buyruk_gecerli_o !== 1'b1 || buyruk_o !== 32'h1000) begin n_fail++; $display("FAIL stall_hold c%0d: got v %b ins %h required 1 00001000", k, buyruk_gecerli_o, buyruk_o); end
        if (bb_ena_o !== 1'b0) begin n_fail++; $display("FAIL stall_ena c%0d: got %b required 0", k, bb_ena_o); end
      end
      if (k == 7) begin
        n_chk++;
        if (n_ena != DEPTH) begin n_fail++; $display("FAIL stall_reads: got %0d required %0d", n_ena, DEPTH); end
      end
      if (k >= 8) begin
        n_chk++;
        if (buyruk_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL stall_gap c%0d: got %b required 1", k, buyruk_gecerli_o); end
      end
      if (buyruk_gecerli_o && coz_hazir_i) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_sb: got ps %h required no entry", buyruk_ps_o); end
        else begin
          e = exp_q.pop_front();
          if (buyruk_ps_o !== e.ps || buyruk_o !== e.ins) begin n_fail++; $display("FAIL stall_sb: got ps %h ins %h required ps %h ins %h", buyruk_ps_o, buyruk_o, e.ps, e.ins); end
        end
      end
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      coz_hazir_i = 1'b1;
      ket_gecerli_i = (k == 1);
      ket_ps_i = 32'h0000_0043;
      #1;
      if (k == 1) begin
        n_chk++;
        if (bb_ena_o !== 1'b0) begin n_fail++; $display("FAIL redir_ena0: got %b required 0", bb_ena_o); end
      end
      if (k == 2) begin
        n_chk++;
        if (bb_ena_o !== 1'b1 || bb_addra_o !== AW'(8'h10)) begin n_fail++; $display("FAIL redir_addr: got ena %b addr %h required 1 10", bb_ena_o, bb_addra_o); end
      end
      if (k == 2 || k == 3 || k == 4) begin
        n_chk++;
        if (buyruk_gecerli_o !== (k == 4)) begin n_fail++; $display("FAIL redir_gecerli c%0d: got %b required %b", k, buyruk_gecerli_o, k == 4); end
      end
      if (buyruk_gecerli_o && coz_hazir_i) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL redir_sb: got ps %h required no entry", buyruk_ps_o); end
        else begin
          e = exp_q.pop_front();
          if (buyruk_ps_o !== e.ps || buyruk_o !== e.ins) begin n_fail++; $display("FAIL redir_sb: got ps %h ins %h required ps %h ins %h", buyruk_ps_o, buyruk_o, e.ps, e.ins); end
        end
      end
      if (k == 1) begin
        exp_q.delete();
        push_stream(32'h40, 20);
      end
    end
  endtask

  task automatic test_double_redirect();
    exp_t e;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      coz_hazir_i = 1'b1;
      ket_gecerli_i = (k <= 2);
      ket_ps_i = (k == 1) ? 32'h40 : 32'h80;
      #1;
      if (k == 1) begin
        n_chk++;
        if (buyruk_gecerli_o !== 1'b1) begin n_fail++; $display("FAIL dbl_pop: got %b required 1", buyruk_gecerli_o); end
      end
      if (k >= 2 && k <= 5) begin
        n_chk++;
        if (buyruk_gecerli_o !== (k == 5)) begin n_fail++; $display("FAIL dbl_gecerli c%0d: got %b required %b", k, buyruk_gecerli_o, k == 5); end
      end
      if (k == 3) begin
        n_chk++;
        if (bb_ena_o !== 1'b1 || bb_addra_o !== AW'(8'h20)) begin n_fail++; $display("FAIL dbl_addr: got ena %b addr %h required 1 20", bb_ena_o, bb_addra_o); end
      end
      if (buyruk_gecerli_o && coz_hazir_i) begin
        n_chk++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL dbl_sb: got ps %h required no entry", buyruk_ps_o); end
        else begin
          e = exp_q.pop_front();
          if (buyruk_ps_o !== e.ps || buyruk_o !== e.ins) begin n_fail++; $display("FAIL dbl_sb: got ps %h ins %h required ps %h ins %h", buyruk_ps_o, buyruk_o, e.ps, e.ins); end
        end
      end
      if (k == 1) exp_q.delete();
      if (k == 2) push_stream(32'h80, 20);
    end
  endtask

  task automatic test_reset_midflight();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ket_gecerli_i = 1'b0;
      coz_hazir_i = (k == 4);
      rst_i = (k >= 5);
      #1;
      if (k == 4) begin
        n_chk++;
        if (buyruk_gecerli_o !== 1'b1 || bb_ena_o !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got v %b ena %b required 1 1", buyruk_gecerli_o, bb_ena_o); end
      end
      if (k == 6) begin
        n_chk += 2;
        if (buyruk_gecerli_o !== 1'b0 || bb_ena_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst: got v %b ena %b required 0 0", buyruk_gecerli_o, bb_ena_o); end
        if (buyruk_o !== 32'h0 || buyruk_ps_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_out: got ins %h ps %h required 0 0", buyruk_o, buyruk_ps_o); end
      end
    end
  endtask

`ifdef BUYRUK_GETIR_SINIR_EN
  task automatic test_sinir();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      coz_hazir_i = 1'b1;
      ket_gecerli_i = (k == 1);
      ket_ps_i = 32'h400;
      #1;
      if (k == 2) begin
        n_chk++;
        if (bb_ena_o !== 1'b0) begin n_fail++; $display("FAIL sinir_ena: got %b required 0", bb_ena_o); end
      end
      if (k == 4) begin
        n_chk++;
        if (buyruk_gecerli_o !== 1'b1 || buyruk_o !== 32'h13 || buyruk_ps_o !== 32'h400 || buyruk_hata_o !== 1'b1)
          begin n_fail++; $display("FAIL sinir_nop: got v %b ins %h ps %h hata %b required 1 13 400 1", buyruk_gecerli_o, buyruk_o, buyruk_ps_o, buyruk_hata_o); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_reset();
    test_stall();
    test_redirect();
    test_double_redirect();
    test_reset_midflight();
    test_startup();
`ifdef BUYRUK_GETIR_SINIR_EN
    test_sinir();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
